rgb2gray_pipe: RTL and testbench
================================

Name: rgb2gray_pipe

Overview:
Pipelined, parametrised RGB-to-grayscale converter with valid/ready handshake. Takes PPC pixels per clock and produces one gray value per pixel. Coefficients and output mode are programmable at run time and latched at start-of-frame. Sits in the camera path between the demosaic/RGB stage and the downscaler/AI input buffer.

Parameters:
DATA_WIDTH, 8, bits per colour channel and per gray output
PPC, 2, pixels per clock (≥1)
COEF_WIDTH, 8, width of each unsigned coefficient
COEF_FRAC, 8, fractional bits of coefficients (1..COEF_WIDTH+2)
USER_WIDTH, 2, sideband bits carried alongside data (e.g. hsync/vsync)
DEF_COEF_R, 77, reset value of red coefficient
DEF_COEF_G, 150, reset value of green coefficient
DEF_COEF_B, 29, reset value of blue coefficient

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_coef_r  in  COEF_WIDTH  red coefficient, sampled on SOF beat
cfg_coef_g  in  COEF_WIDTH  green coefficient, sampled on SOF beat
cfg_coef_b  in  COEF_WIDTH  blue coefficient, sampled on SOF beat
cfg_mode  in  2  00 weighted, 01 red only, 10 green only, 11 blue only; sampled on SOF beat
in_valid  in  1  input beat valid
in_ready  out  1  pipeline can accept a beat
in_sof  in  1  beat is first of frame
in_user  in  USER_WIDTH  sideband, passed through unchanged
in_red  in  PPC*DATA_WIDTH  red, pixel i at [i*DATA_WIDTH +: DATA_WIDTH]
in_green  in  PPC*DATA_WIDTH  green, same packing
in_blue  in  PPC*DATA_WIDTH  blue, same packing
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_sof  out  1  SOF aligned with out_gray
out_user  out  USER_WIDTH  sideband aligned with out_gray
out_gray  out  PPC*DATA_WIDTH  gray, same packing

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous assert, active-low; all registers are clocked on rising clk.
- Reset values: out_valid=0, out_sof=0, out_user=0, out_gray=0. All stage valids 0. Active coefficients = DEF_COEF_R/G/B. Active mode = 00.
- Pipeline: 3 register stages. Latency is exactly 3 cycles from an accepted input beat to out_valid when out_ready is held 1.
  - S1: products p_c = channel × coef_c, width DATA_WIDTH+COEF_WIDTH.
  - S2: sum = p_r+p_g+p_b+2^(COEF_FRAC-1), width DATA_WIDTH+COEF_WIDTH+2; no overflow is possible.
  - S3: y = sum>>COEF_FRAC, saturated to 2^DATA_WIDTH-1. The mode mux is applied here; modes 01/10/11 output the raw delayed channel, bypassing the arithmetic.
- Stall model: global enable adv = ~out_valid | out_ready. in_ready = adv (combinational). When adv=0, every stage holds its contents.
- Each stage has a valid bit. Bubbles propagate as valid=0. Data registers may update on bubbles; the valid bits gate the output.
- An input beat is accepted when in_valid & in_ready.
- SOF latching:
  - On an accepted beat with in_sof=1, the cfg_* inputs are captured into the active registers.
  - That same beat already uses the new cfg values: a combinational mux selects cfg_* when the beat is SOF.
  - cfg_* changes at any other time have no effect.
- Each beat carries its own mode and coefficients down the pipe. A frame boundary inside the pipe therefore never mixes settings.
- out_sof, out_user and out_valid travel with their beat. All PPC lanes are processed identically and in parallel.
- out_valid and data stay stable while out_valid=1 & out_ready=0.
- Reset mid-frame: all in-flight beats are discarded and the coefficients revert to their defaults.

Test Plan:
- Defaults, PPC=2, R=G=B=255 on both lanes, out_ready=1 -> out_gray=0xFFFF exactly 3 cycles after acceptance.
- Rounding, defaults: pixel (R=2,G=0,B=0) -> (154+128)>>8 = 1. Pixel (R=1,0,0) -> 0. Pixel (0,1,0) -> (150+128)>>8 = 1.
- Saturation: SOF beat with coefs 255/255/255, RGB=255 -> sum 195203>>8 = 762 -> out 255.
- Config timing:
  - Change cfg_coef_r to 0 mid-frame -> following beats still use 77.
  - Next SOF beat with R=200,G=B=0 -> out 0 on that beat.
  - Mode 10 on SOF -> out = green lane values unchanged.
- Backpressure: stream 8 beats with out_ready toggling 1,0,0,1,... -> no loss or duplication, order preserved, in_ready low only while out_valid & ~out_ready, user/sof aligned.
- Reset: assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately (asynchronous), no stale beats after release, coefficients back to 77/150/29.

Source files
------------

// File: rtl/rgb2gray_pipe.sv
// -----------------------------------------------------------------------------
// rgb2gray_pipe
//   Pipelined RGB-to-grayscale converter, PPC pixels per clock, with a
//   valid/ready handshake. Coefficients and output mode are latched from the
//   cfg_* inputs on every accepted start-of-frame beat. That same beat already
//   uses the new settings.
//
// Handshake: a beat moves on a rising edge when valid and ready are both high.
//   in_ready = ~out_valid | out_ready. The whole pipe advances as one unit, so
//   when out_ready is low with out_valid high, every stage holds. out_valid and
//   its data stay stable until they are taken.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_coef_r/g/b      unsigned coefficients (COEF_FRAC fractional bits)
//   cfg_mode            00 weighted, 01 red, 10 green, 11 blue
//   in_valid/in_ready   input handshake
//   in_sof, in_user     start-of-frame flag and sideband, travel with the beat
//   in_red/green/blue   pixel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready output handshake
//   out_sof, out_user   aligned with out_gray
//   out_gray            gray value per pixel, same packing as the inputs
//
// Pipeline (3 register stages)
//   S1 per-channel products, S2 rounded sum, S3 shift/saturate + mode mux.
// -----------------------------------------------------------------------------
module rgb2gray_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int PPC        = 2,
    parameter int COEF_WIDTH = 8,
    parameter int COEF_FRAC  = 8,
    parameter int USER_WIDTH = 2,
    parameter int DEF_COEF_R = 77,
    parameter int DEF_COEF_G = 150,
    parameter int DEF_COEF_B = 29
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [COEF_WIDTH-1:0]     cfg_coef_r,
    input  logic [COEF_WIDTH-1:0]     cfg_coef_g,
    input  logic [COEF_WIDTH-1:0]     cfg_coef_b,
    input  logic [1:0]                cfg_mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sof,
    input  logic [USER_WIDTH-1:0]     in_user,
    input  logic [PPC*DATA_WIDTH-1:0] in_red,
    input  logic [PPC*DATA_WIDTH-1:0] in_green,
    input  logic [PPC*DATA_WIDTH-1:0] in_blue,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sof,
    output logic [USER_WIDTH-1:0]     out_user,
    output logic [PPC*DATA_WIDTH-1:0] out_gray
);

    localparam int PW = DATA_WIDTH + COEF_WIDTH;   // product width
    localparam int SW = PW + 2;                    // sum width, holds 3 products + rounding

    localparam logic [SW-1:0] RND  = SW'(1) << (COEF_FRAC - 1);
    localparam logic [SW-1:0] YMAX = SW'((1 << DATA_WIDTH) - 1);

    localparam logic [COEF_WIDTH-1:0] DEF_R = COEF_WIDTH'(DEF_COEF_R);
    localparam logic [COEF_WIDTH-1:0] DEF_G = COEF_WIDTH'(DEF_COEF_G);
    localparam logic [COEF_WIDTH-1:0] DEF_B = COEF_WIDTH'(DEF_COEF_B);

    // Global advance and input acceptance
    logic w_adv;
    logic w_accept;
    logic w_sof_beat;

    // Active (frame) settings and the settings this beat actually uses
    logic [COEF_WIDTH-1:0] r_coef_r, r_coef_g, r_coef_b;
    logic [1:0]            r_mode;
    logic [COEF_WIDTH-1:0] w_coef_r, w_coef_g, w_coef_b;
    logic [1:0]            w_mode;

    // S0 combinational per-lane results
    logic [PPC-1:0][PW-1:0]         w_pr, w_pg, w_pb;
    logic [PPC-1:0][DATA_WIDTH-1:0] w_raw;

    // Stage 1
    logic                           r_s1_valid;
    logic                           r_s1_sof;
    logic [USER_WIDTH-1:0]          r_s1_user;
    logic [1:0]                     r_s1_mode;
    logic [PPC-1:0][PW-1:0]         r_s1_pr, r_s1_pg, r_s1_pb;
    logic [PPC-1:0][DATA_WIDTH-1:0] r_s1_raw;

    // Stage 2
    logic                           r_s2_valid;
    logic                           r_s2_sof;
    logic [USER_WIDTH-1:0]          r_s2_user;
    logic [1:0]                     r_s2_mode;
    logic [PPC-1:0][SW-1:0]         r_s2_sum;
    logic [PPC-1:0][DATA_WIDTH-1:0] r_s2_raw;

    // S1->S2 and S2->S3 combinational results
    logic [PPC-1:0][SW-1:0]         w_sum;
    logic [PPC-1:0][SW-1:0]         w_shift;
    logic [PPC-1:0][DATA_WIDTH-1:0] w_y;

    assign w_adv      = ~out_valid | out_ready;
    assign in_ready   = w_adv;
    assign w_accept   = in_valid & w_adv;
    assign w_sof_beat = in_valid & in_sof;

    // An SOF beat bypasses the active registers so it already sees the new cfg.
    assign w_coef_r = w_sof_beat ? cfg_coef_r : r_coef_r;
    assign w_coef_g = w_sof_beat ? cfg_coef_g : r_coef_g;
    assign w_coef_b = w_sof_beat ? cfg_coef_b : r_coef_b;
    assign w_mode   = w_sof_beat ? cfg_mode   : r_mode;

    // Products and the bypass channel; the bypass channel is chosen here so
    // only one raw lane value has to travel down the pipe.
    always_comb begin
        w_pr  = '0;
        w_pg  = '0;
        w_pb  = '0;
        w_raw = '0;
        for (int l = 0; l < PPC; l++) begin
            w_pr[l] = PW'(in_red[l*DATA_WIDTH +: DATA_WIDTH])   * PW'(w_coef_r);
            w_pg[l] = PW'(in_green[l*DATA_WIDTH +: DATA_WIDTH]) * PW'(w_coef_g);
            w_pb[l] = PW'(in_blue[l*DATA_WIDTH +: DATA_WIDTH])  * PW'(w_coef_b);
            case (w_mode)
                2'b01:   w_raw[l] = in_red[l*DATA_WIDTH +: DATA_WIDTH];
                2'b10:   w_raw[l] = in_green[l*DATA_WIDTH +: DATA_WIDTH];
                2'b11:   w_raw[l] = in_blue[l*DATA_WIDTH +: DATA_WIDTH];
                default: w_raw[l] = '0;
            endcase
        end
    end

    always_comb begin
        w_sum = '0;
        for (int l = 0; l < PPC; l++) begin
            w_sum[l] = SW'(r_s1_pr[l]) + SW'(r_s1_pg[l]) + SW'(r_s1_pb[l]) + RND;
        end
    end

    always_comb begin
        w_shift = '0;
        w_y     = '0;
        for (int l = 0; l < PPC; l++) begin
            w_shift[l] = r_s2_sum[l] >> COEF_FRAC;
            if (r_s2_mode != 2'b00) begin
                w_y[l] = r_s2_raw[l];
            end else if (w_shift[l] > YMAX) begin
                w_y[l] = '1;
            end else begin
                w_y[l] = w_shift[l][DATA_WIDTH-1:0];
            end
        end
    end

    // Active settings: only an accepted SOF beat updates them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coef_r <= DEF_R;
            r_coef_g <= DEF_G;
            r_coef_b <= DEF_B;
            r_mode   <= 2'b00;
        end else if (w_accept && in_sof) begin
            r_coef_r <= cfg_coef_r;
            r_coef_g <= cfg_coef_g;
            r_coef_b <= cfg_coef_b;
            r_mode   <= cfg_mode;
        end
    end

    // Pipeline stages, all gated by the single advance enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_user  <= '0;
            r_s1_mode  <= 2'b00;
            r_s1_pr    <= '0;
            r_s1_pg    <= '0;
            r_s1_pb    <= '0;
            r_s1_raw   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_sof   <= 1'b0;
            r_s2_user  <= '0;
            r_s2_mode  <= 2'b00;
            r_s2_sum   <= '0;
            r_s2_raw   <= '0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_user   <= '0;
            out_gray   <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s1_sof   <= in_sof;
            r_s1_user  <= in_user;
            r_s1_mode  <= w_mode;
            r_s1_pr    <= w_pr;
            r_s1_pg    <= w_pg;
            r_s1_pb    <= w_pb;
            r_s1_raw   <= w_raw;

            r_s2_valid <= r_s1_valid;
            r_s2_sof   <= r_s1_sof;
            r_s2_user  <= r_s1_user;
            r_s2_mode  <= r_s1_mode;
            r_s2_sum   <= w_sum;
            r_s2_raw   <= r_s1_raw;

            out_valid  <= r_s2_valid;
            out_sof    <= r_s2_sof;
            out_user   <= r_s2_user;
            out_gray   <= w_y;
        end
    end

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// -----------------------------------------------------------------------------
// tb_rgb2gray_pipe
//   Directed bench for rgb2gray_pipe (PPC=2, 8-bit data, default coefficients
//   77/150/29). Drivers push the hand-computed {sof, user, gray} of every
//   accepted beat into exp_q; a negedge monitor pops and compares whenever an
//   output beat is taken, and also watches in_ready and stall stability.
// -----------------------------------------------------------------------------
module tb_rgb2gray_pipe;

    localparam int DW  = 8;
    localparam int PPC = 2;
    localparam int UW  = 2;
    localparam int CW  = 8;
    localparam int EW  = 1 + UW + PPC*DW;

    logic              clk;
    logic              rst_n;
    logic [CW-1:0]     cfg_coef_r, cfg_coef_g, cfg_coef_b;
    logic [1:0]        cfg_mode;
    logic              in_valid;
    logic              in_ready;
    logic              in_sof;
    logic [UW-1:0]     in_user;
    logic [PPC*DW-1:0] in_red, in_green, in_blue;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_sof;
    logic [UW-1:0]     out_user;
    logic [PPC*DW-1:0] out_gray;

    int errors = 0;
    int checks = 0;
    logic [EW-1:0] exp_q[$];

    rgb2gray_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_coef_r (cfg_coef_r),
        .cfg_coef_g (cfg_coef_g),
        .cfg_coef_b (cfg_coef_b),
        .cfg_mode   (cfg_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sof     (in_sof),
        .in_user    (in_user),
        .in_red     (in_red),
        .in_green   (in_green),
        .in_blue    (in_blue),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sof    (out_sof),
        .out_user   (out_user),
        .out_gray   (out_gray)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- downstream backpressure: 1,0,0,1 repeating ----------------
    bit       bp_en  = 1'b0;
    int       bp_k   = 0;
    logic [3:0] bp_pat = 4'b1001;

    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            out_ready = bp_pat[bp_k];
            bp_k      = (bp_k + 1) % 4;
        end else begin
            out_ready = 1'b1;
            bp_k      = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1. Holds the beat until accepted, pushes the expected
    // response, and returns at posedge+1 after the accepting edge.
    task automatic send(input logic sof, input logic [UW-1:0] user,
                        input logic [15:0] r, input logic [15:0] g, input logic [15:0] b,
                        input logic [15:0] exp_gray, input bit push);
        int n;
        in_valid = 1'b1;
        in_sof   = sof;
        in_user  = user;
        in_red   = r;
        in_green = g;
        in_blue  = b;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
        end else if (push) begin
            exp_q.push_back({sof, user, exp_gray});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic          stalled_prev = 1'b0;
    logic [EW-1:0] held;
    logic [EW-1:0] exp_beat;

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled_prev = 1'b0;
        end else begin
            check("in_ready", in_ready, (!out_valid || out_ready));
            if (stalled_prev) begin
                check("stall_hold", {out_valid, out_sof, out_user, out_gray}, {1'b1, held});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", {out_sof, out_user, out_gray});
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("out_beat", {out_sof, out_user, out_gray}, exp_beat);
                end
            end
            stalled_prev = out_valid && !out_ready;
            held         = {out_sof, out_user, out_gray};
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] v;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sof     = 1'b0;
        in_user    = '0;
        in_red     = '0;
        in_green   = '0;
        in_blue    = '0;
        cfg_coef_r = 8'd77;
        cfg_coef_g = 8'd150;
        cfg_coef_b = 8'd29;
        cfg_mode   = 2'b00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sof",   out_sof,   0);
        check("rst_out_user",  out_user,  0);
        check("rst_out_gray",  out_gray,  0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // White on both lanes with defaults, plus exact 3-cycle latency.
        send(1'b1, 2'b01, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
        @(negedge clk); check("latency_c1", out_valid, 0);
        @(negedge clk); check("latency_c2", out_valid, 0);
        @(negedge clk); check("latency_c3", out_valid, 1);
        @(posedge clk); #1;

        // Rounding with defaults: (2,0,0)->1, (1,0,0)->0, (0,1,0)->1, (0,0,0)->0.
        send(1'b0, 2'b00, {8'd1, 8'd2}, 16'h0000, 16'h0000, {8'd0, 8'd1}, 1'b1);
        send(1'b0, 2'b01, 16'h0000, {8'd0, 8'd1}, 16'h0000, {8'd0, 8'd1}, 1'b1);

        // Mid-frame cfg change is ignored: 200*77+128 >> 8 = 60.
        cfg_coef_r = 8'd0;
        send(1'b0, 2'b10, {8'd200, 8'd200}, 16'h0000, 16'h0000, {8'd60, 8'd60}, 1'b1);

        // New SOF latches coef_r=0 for this beat and the rest of the frame.
        send(1'b1, 2'b11, {8'd200, 8'd200}, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        cfg_coef_r = 8'd77;
        send(1'b0, 2'b00, {8'd100, 8'd200}, 16'h0000, 16'h0000, 16'h0000, 1'b1);

        // Saturation with 255/255/255: lane1 white -> 762 -> 255; lane0 (10,20,30) -> 60.
        cfg_coef_r = 8'd255;
        cfg_coef_g = 8'd255;
        cfg_coef_b = 8'd255;
        send(1'b1, 2'b01, {8'd255, 8'd10}, {8'd255, 8'd20}, {8'd255, 8'd30}, {8'd255, 8'd60}, 1'b1);
        cfg_coef_r = 8'd77;
        cfg_coef_g = 8'd150;
        cfg_coef_b = 8'd29;
        // Still 255s in this frame: (1,1,1) -> (765+128)>>8 = 3.
        send(1'b0, 2'b10, {8'd0, 8'd1}, {8'd0, 8'd1}, {8'd0, 8'd1}, {8'd0, 8'd3}, 1'b1);

        // Green-only mode, held for the frame even after cfg_mode changes.
        cfg_mode = 2'b10;
        send(1'b1, 2'b00, {8'h11, 8'h22}, {8'hC3, 8'h5A}, {8'h33, 8'h44}, {8'hC3, 8'h5A}, 1'b1);
        cfg_mode = 2'b00;
        send(1'b0, 2'b01, 16'hFFFF, {8'h07, 8'h80}, 16'h0000, {8'h07, 8'h80}, 1'b1);

        // Blue-only then red-only frames.
        cfg_mode = 2'b11;
        send(1'b1, 2'b10, {8'd1, 8'd2}, {8'd3, 8'd4}, {8'hAB, 8'hCD}, {8'hAB, 8'hCD}, 1'b1);
        cfg_mode = 2'b01;
        send(1'b1, 2'b11, {8'h9E, 8'h01}, {8'h10, 8'h20}, {8'h30, 8'h40}, {8'h9E, 8'h01}, 1'b1);
        cfg_mode = 2'b00;
        drain();

        // Backpressure: 8 beats of grey pixels (coefs sum to 256 -> gray = value).
        bp_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = 8'(i*30 + 7);
            send((i == 0), UW'(i), {~v, v}, {~v, v}, {~v, v}, {~v, v}, 1'b1);
        end
        drain();
        bp_en = 1'b0;
        @(posedge clk); #1;

        // Reset with 3 beats in flight from a green-only, coef_r=0 frame.
        cfg_mode   = 2'b10;
        cfg_coef_r = 8'd0;
        send(1'b1, 2'b01, 16'h0101, 16'h0202, 16'h0303, 16'h0000, 1'b0);
        send(1'b0, 2'b10, 16'h0404, 16'h0505, 16'h0606, 16'h0000, 1'b0);
        send(1'b0, 2'b11, 16'h0707, 16'h0808, 16'h0909, 16'h0000, 1'b0);
        check("inflight_before_reset", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", out_valid, 0);
        check("async_reset_gray",  out_gray,  0);
        check("async_reset_sof",   out_sof,   0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("no_stale_after_reset", out_valid, 0);
        // Defaults back: non-SOF (200,0,0) in weighted mode with coef_r=77 -> 60.
        send(1'b0, 2'b00, {8'd200, 8'd200}, 16'h0000, 16'h0000, {8'd60, 8'd60}, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        errors++;
        checks++;
        $display("FAIL global_timeout: got no completion expected finish before 200000");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
